// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux slice: selection-mode encodings.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping around.
// Purely combinational; scanning offsets 1..CHANNELS from ptr is the
// rotate / priority-encode / rotate-back structure written as one loop.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     idx,
  output logic                anyGrant
);

  int unsigned     cand;
  logic [SELW-1:0] candIdx;

  // Scan from the channel after ptr; first requester wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    anyGrant = 1'b0;
    cand     = 0;
    candIdx  = '0;
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      cand    = (32'(ptr) + off) % CHANNELS;
      candIdx = SELW'(cand);
      if (!anyGrant && req[candIdx]) begin
        grant[candIdx] = 1'b1;
        idx            = candIdx;
        anyGrant       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Fixed mode picks channel sel; round-robin mode uses a fair arbiter.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] dIn,
  input  logic [CHANNELS-1:0]       valIn,
  output logic [CHANNELS-1:0]       rdyIn,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          dOut,
  output logic                      valOut,
  input  logic                      rdyOut,
  output logic [SELW-1:0]           chanOut
);

  logic [SELW-1:0]     ptr;
  logic                load;

  logic [CHANNELS-1:0] fixGrant;
  logic                fixValid;

  logic [CHANNELS-1:0] rrGrant;
  logic [SELW-1:0]     rrIdx;
  logic                rrValid;

  logic [CHANNELS-1:0] grantVec;
  logic [SELW-1:0]     grantIdx;
  logic                grantValid;
  logic [WIDTH-1:0]    selData;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) uArb (
    .req      (valIn),
    .ptr      (ptr),
    .grant    (rrGrant),
    .idx      (rrIdx),
    .anyGrant (rrValid)
  );

  // Fixed-mode decode: only channel sel is considered; out-of-range sel matches nothing.
  always_comb begin
    fixGrant = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      fixGrant[i] = (sel == SELW'(i)) && valIn[i];
    end
    fixValid = |fixGrant;
  end

  // Mode mux, load enable, handshake and data select.
  always_comb begin
    load = !valOut || rdyOut;
    if (mode == MODE_RR) begin
      grantVec   = rrGrant;
      grantIdx   = rrIdx;
      grantValid = rrValid;
    end else begin
      grantVec   = fixGrant;
      grantIdx   = sel;
      grantValid = fixValid;
    end
    rdyIn = (load && grantValid && !rst) ? grantVec : '0;
    selData = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grantVec[i]) selData = dIn[i*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dOut    <= '0;
      valOut  <= 1'b0;
      chanOut <= '0;
      ptr     <= SELW'(CHANNELS - 1);
    end else if (load) begin
      if (grantValid) begin
        dOut    <= selData;
        chanOut <= grantIdx;
        valOut  <= 1'b1;
        if (mode == MODE_RR) ptr <= grantIdx;
      end else begin
        valOut <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshaking on every channel. It succeeds the plain 2:1 combinational mux. It supports two selection modes: fixed, where the channel is picked by an external select, and round-robin, where it is picked by an internal fair arbiter. It sits between multiple producers (register-file read ports, ALU/memory result paths) and a single consumer, and accepts one transfer per cycle at full throughput.

## Interface
Parameters:
- WIDTH, 8, data width per channel.
- CHANNELS, 4, number of input channels (≥2).
- SELW, $clog2(CHANNELS), width of select and channel-index signals.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- dIn  input  CHANNELS*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- valIn  input  CHANNELS  per-channel valid.
- rdyIn  output  CHANNELS  per-channel ready; combinational, one-hot or zero.
- mode  input  1  selection mode; 0 = fixed, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- dOut  output  WIDTH  registered output data.
- valOut  output  1  output register holds valid data.
- rdyOut  input  1  consumer ready.
- chanOut  output  SELW  index of the channel that supplied dOut.

## Operation
- Output register contents: dOut, chanOut and valOut.
- The register can load (load = 1) when valOut = 0 or rdyOut = 1.
- Fixed mode: the grant goes to channel sel if sel < CHANNELS and valIn[sel] = 1. Otherwise there is no grant, and other channels are ignored even if valid.
- Round-robin mode: the grant goes to the first channel with valIn set, scanning ptr+1, ptr+2, … (mod CHANNELS), wrapping around. ptr is the index of the last channel accepted in round-robin mode.
- rdyIn[g] = load AND grant valid, for the granted channel g only. All other rdyIn bits are 0.
- Transfer in: rdyIn[g] & valIn[g]. On that edge dOut ← dIn[g], chanOut ← g, valOut ← 1.
- ptr update: ptr ← g only on an accepted round-robin transfer. Fixed-mode transfers leave ptr unchanged.
- Drain without refill: if rdyOut = 1, valOut = 1 and there is no grant, then valOut ← 0. dOut and chanOut hold their last values.
- Stall: if valOut = 1 and rdyOut = 0, then dOut, chanOut and valOut hold, and all rdyIn = 0.
- Mode or sel changes affect only the next arbitration. A word already in the output register is unaffected.
- rdyIn must not depend on valIn of non-granted channels in fixed mode. In either mode rdyIn depends only on valIn, mode, sel, ptr, valOut and rdyOut.

## Timing
- Latency: an input accepted at edge n appears on dOut/valOut after edge n, and is consumed at the first edge with rdyOut = 1.
- Throughput: one word per cycle while rdyOut stays 1 and some channel is granted.
- Reset values: dOut = 0, valOut = 0, chanOut = 0, ptr = CHANNELS-1 (so channel 0 has first priority), rdyIn = 0 during reset.
- Reset mid-operation: a word held in the output register is discarded. No handshake completes on the reset edge.
- Simultaneous drain and load in the same cycle are allowed, with no bubble.
- Round-robin with only one valid channel: that channel is granted every cycle.
- Round-robin with all channels valid: grants go 0, 1, …, CHANNELS-1, 0, …

## Structure
- Shared package stream_mux_pkg holds MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
- Sub-module rr_arbiter (parameter CHANNELS):
  - inputs: request vector, ptr
  - outputs: one-hot grant, encoded index, any-grant
  - purely combinational rotate/priority-encode/rotate-back.
- Top level holds the output register, ptr, fixed-mode decode, load logic and the mode mux between the fixed and arbiter grants.

## Test plan
- Reset: assert rst for 2 cycles with all valIn = 1 -> valOut = 0, dOut = 0, chanOut = 0, rdyIn = 0. After release in round-robin mode, the first accepted channel is 0.
- Fixed mode, WIDTH = 8, CHANNELS = 4, dIn[i] = 8'h10+i, all valid, rdyOut = 1, sel stepped 0..3 -> dOut = 8'h10..8'h13 one cycle after each sel, chanOut = sel, rdyIn one-hot at sel. With sel = 2 and valIn[2] = 0 -> no grant and valOut falls to 0.
- Round-robin, all four channels valid, rdyOut = 1 for 8 cycles -> chanOut sequence 0,1,2,3,0,1,2,3, valOut continuously 1.
- Round-robin with valIn = 4'b1010 -> chanOut alternates 1, 3, 1, 3. Then drop valIn[3] -> channel 1 every cycle.
- Backpressure: with valOut = 1, hold rdyOut = 0 for 3 cycles -> dOut/chanOut stable and rdyIn = 0. Raise rdyOut -> the next word loads on the same edge the held word drains, with no bubble.
- Mode switch while stalled: a word from channel 2 is held, switch mode from 1 to 0 with sel = 0 -> the held word is still delivered with chanOut = 2, and the next word comes from channel 0.
